// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the store-size encodings (shared with the core load path), the FSM
// state encoding and the latched request payload type.
package dmem_responder_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned CNT_W     = 4;

  // RISC-V funct3 store sizes
  localparam logic [2:0] MEM_B = 3'b000;
  localparam logic [2:0] MEM_H = 3'b001;
  localparam logic [2:0] MEM_W = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    COMMIT = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic            we;
    logic [2:0]      mem_ctrl;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } req_t;

  function automatic logic is_legal_size(input logic [2:0] ctrl);
    return (ctrl == MEM_B) || (ctrl == MEM_H) || (ctrl == MEM_W);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the core (master) and the responder (slave).
// req_*: valid/ready request channel; rsp_*: valid/ready response channel.
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_mem_ctrl;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_mem_ctrl, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_mem_ctrl, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_responder_store_lane_gen.sv
// Store lane generator: maps a right-aligned store onto byte lanes.
// Ports: i_mem_ctrl (store size), i_addr_lo (byte offset in word),
//        i_wdata (right-aligned data), o_be_c (byte enables),
//        o_wdata_c (lane-replicated data), o_misalign_c (sh/sw misaligned).
// Illegal sizes yield no enables; the caller flags them separately.
module dmem_responder_store_lane_gen
  import dmem_responder_pkg::*;
(
  input  logic [2:0]           i_mem_ctrl,
  input  logic [1:0]           i_addr_lo,
  input  logic [XLEN-1:0]      i_wdata,
  output logic [NUM_LANES-1:0] o_be_c,
  output logic [XLEN-1:0]      o_wdata_c,
  output logic                 o_misalign_c
);

  // Replicating the data across lanes lets the enables alone select the target bytes
  always_comb begin
    o_be_c       = '0;
    o_wdata_c    = '0;
    o_misalign_c = 1'b0;
    case (i_mem_ctrl)
      MEM_B: begin
        o_be_c    = 4'b0001 << i_addr_lo;
        o_wdata_c = {4{i_wdata[7:0]}};
      end
      MEM_H: begin
        o_be_c       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata_c    = {2{i_wdata[15:0]}};
        o_misalign_c = i_addr_lo[0];
      end
      MEM_W: begin
        o_be_c       = 4'b1111;
        o_wdata_c    = i_wdata;
        o_misalign_c = |i_addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait states.
// Ports: clk, reset (sync, active-high), bus (slave side of dmem_responder_if).
// One request in flight: accept -> optional BUSY wait -> COMMIT -> RESP.
// Stores merge into the word array; the response carries the raw/post-store word.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 0
)
(
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  req_t                   r_req;
  logic                   r_req_ready;
  logic                   r_rsp_valid;
  logic                   r_rsp_err;
  logic [XLEN-1:0]        r_rsp_rdata;
  logic [XLEN-1:0]        r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0]  w_idx;
  logic [XLEN-1:0]        w_cur;
  logic [XLEN-1:0]        w_merged;
  logic [XLEN-1:0]        w_lane_wdata;
  logic [NUM_LANES-1:0]   w_be;
  logic                   w_misalign;
  logic                   w_err;
  logic                   w_fire;
  logic                   w_mem_we;
  logic                   w_unused_addr;

  // Upper address bits are ignored so accesses wrap modulo the array size
  assign w_idx         = r_req.addr[ADDR_WIDTH+1:2];
  assign w_cur         = r_mem[w_idx];
  assign w_unused_addr = ^r_req.addr[XLEN-1:ADDR_WIDTH+2];

  dmem_responder_store_lane_gen u_store_lane_gen (
    .i_mem_ctrl   (r_req.mem_ctrl),
    .i_addr_lo    (r_req.addr[1:0]),
    .i_wdata      (r_req.wdata),
    .o_be_c       (w_be),
    .o_wdata_c    (w_lane_wdata),
    .o_misalign_c (w_misalign)
  );

  // Byte-enable merge of the store into the current word
  always_comb begin
    w_merged = w_cur;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      if (w_be[i]) w_merged[8*i +: 8] = w_lane_wdata[8*i +: 8];
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (bus.req_valid) w_state_nxt = (WAIT_CYCLES != 0) ? BUSY : COMMIT;
      BUSY:   if (r_cnt <= CNT_W'(1)) w_state_nxt = COMMIT;
      COMMIT: w_state_nxt = RESP;
      RESP:   if (bus.rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM output decode; loads never raise errors
  always_comb begin
    w_fire   = (r_state == IDLE) && bus.req_valid;
    w_err    = r_req.we && (w_misalign || !is_legal_size(r_req.mem_ctrl));
    w_mem_we = (r_state == COMMIT) && r_req.we && !w_err;
  end

  // Request latch, wait counter and registered handshake/response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req       <= '0;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_req_ready <= (w_state_nxt == IDLE);
      r_rsp_valid <= (w_state_nxt == RESP);
      if (w_fire) begin
        r_req <= req_t'{we: bus.req_we, mem_ctrl: bus.req_mem_ctrl,
                        addr: bus.req_addr, wdata: bus.req_wdata};
        r_cnt <= CNT_W'(WAIT_CYCLES);
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (r_state == COMMIT) begin
        r_rsp_rdata <= w_mem_we ? w_merged : w_cur;
        r_rsp_err   <= w_err;
      end
    end
  end

  // Single write per store, issued only from the one-cycle COMMIT state
  always_ff @(posedge clk) begin
    if (w_mem_we && !reset) r_mem[w_idx] <= w_merged;
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder that sits at the memory end of the core's load/store port.
- Accepts one request at a time: word-aligned byte address, store size, store data, write enable.
- Merges byte/half/word stores into an internal word array and returns the full raw 32-bit word for loads; byte/half extraction stays in the core's load path.
- Programmable wait states model slow memory, so the core side must honour a valid/ready handshake.

Parameters:
ADDR_WIDTH, 10, word-address bits; array depth = 2**ADDR_WIDTH words.
WAIT_CYCLES, 0, extra cycles between request accept and memory commit (0..15).

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_mem_ctrl  input  3  store size, RISC-V funct3: 000 sb, 001 sh, 010 sw; ignored for loads
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts response
rsp_rdata  output  32  raw word at addr[ADDR_WIDTH+1:2]; post-store word for stores
rsp_err  output  1  misaligned access or illegal mem_ctrl; no write performed

Behaviour:
- Synchronous reset:
  - state = IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0.
  - Array contents are not cleared.
  - A reset in BUSY abandons the request; nothing is written.
  - A reset in RESP drops the response.
- FSM IDLE:
  - req_ready = 1 only in IDLE.
  - Handshake fires when req_valid & req_ready.
  - On fire, latch we/mem_ctrl/addr/wdata and set counter = WAIT_CYCLES.
  - Go to BUSY if WAIT_CYCLES > 0, else COMMIT.
- FSM BUSY: decrement counter each cycle; go to COMMIT when counter reaches 1.
- FSM COMMIT (single cycle):
  - Check alignment: sh needs addr[0] = 0; sw needs addr[1:0] = 00; mem_ctrl 011..111 on a store is illegal.
  - On error: no write; rsp_err = 1; rsp_rdata = current word.
  - Otherwise, for a store, write the merged word via byte enables, then go to RESP.
  - rsp_rdata is loaded with the merged word for a store, or the current word for a load.
- FSM RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err held stable until rsp_valid & rsp_ready.
  - On that handshake, return to IDLE and clear rsp_valid.
  - No new request is accepted in the same cycle (req_ready = 0 outside IDLE).
- Latency: accept at cycle T gives rsp_valid first high at T+2+WAIT_CYCLES. With rsp_ready held high, the next accept can occur at T+3+WAIT_CYCLES.
- Byte lanes:
  - sb: lane addr[1:0] gets wdata[7:0].
  - sh: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
  - sw: all lanes.
  - Unwritten lanes keep their old value.
- Address:
  - Bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo the array size; no error is raised.
  - Loads never raise alignment errors; the raw word is returned.
- Exactly one array write per accepted store, never repeated during response backpressure.

Decomposition:
- Shared package holds:
  - mem_ctrl encodings MEM_B = 3'b000, MEM_H = 3'b001, MEM_W = 3'b010 (shared with the core's load path);
  - FSM state encoding IDLE/BUSY/COMMIT/RESP.
- One natural combinational sub-module, store_lane_gen:
  - inputs: mem_ctrl, addr[1:0], wdata;
  - outputs: 4-bit byte enable, lane-shifted write data, misalign flag.
  - Instantiated once.

Test Plan:
- WAIT_CYCLES=0: sw 0x11223344 to 0x04, then load 0x04 -> rsp_rdata 0x11223344, rsp_err 0; each rsp_valid 2 cycles after accept.
- After above, sb 0xAB to 0x05 then sh 0xBEEF to 0x06 -> responses 0x1122AB44 then 0xBEEFAB44; load 0x04 returns 0xBEEFAB44.
- sw to 0x02 and sh to 0x07 -> rsp_err 1 both; load 0x00/0x04 show unchanged contents.
- WAIT_CYCLES=2, accept at cycle 0 -> rsp_valid rises cycle 4; req_ready low cycles 1-4. Then hold rsp_ready low 3 cycles -> rsp_rdata/rsp_err stable, single write only.
- Assert reset during BUSY of sw 0xDEADBEEF to 0x08 -> next cycle rsp_valid 0, req_ready 1; load 0x08 returns prior value.
- ADDR_WIDTH=10: sw 0xCAFEF00D to 0x1000 -> load 0x0000 returns 0xCAFEF00D (wrap).
